// File: rtl/serving_uart_tx_if.sv
// Wishbone slave bus bundle for the serving UART transmitter.
//   adr : register select (0=DATA, 1=STATUS)
//   dat : write data, only [7:0] used
//   we  : write enable
//   cyc : cycle/strobe, held by the master until ack
//   rdt : read data, valid in the ack cycle, 0 otherwise
//   ack : one-cycle acknowledge
interface serving_uart_tx_if;
    logic        adr;
    logic [31:0] dat;
    logic        we;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;

    modport master (output adr, dat, we, cyc, input rdt, ack);
    modport slave  (input adr, dat, we, cyc, output rdt, ack);
endinterface

// File: rtl/serving_uart_tx.sv
// UART transmitter peripheral: Wishbone slave, byte FIFO and 8N1 serialiser.
//   i_clk : system clock
//   i_rst : asynchronous active-low reset
//   wb    : Wishbone slave port (DATA write pushes a byte, reads return STATUS)
//   o_tx  : serial output, idle high, driven straight from a flop
module serving_uart_tx #(
    parameter int unsigned DIVISOR = 139,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    serving_uart_tx_if.slave   wb,
    output logic               o_tx
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned BW    = 16;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(DIVISOR - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_nx;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic [7:0]         mem [DEPTH];
    logic               overflow;
    logic [BW-1:0]      baud, baud_nx;
    logic [2:0]         bit_idx, bit_nx;
    logic [7:0]         sh, sh_nx;
    logic               tx_nx;
    logic               pop;

    logic full, empty, busy;
    logic accept, wr_data, push, ovf_set, ovf_clr;
    logic [31:0] status;
    logic unused_dat;

    assign unused_dat = ^wb.dat[31:8];

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == CW'(0));
    assign busy    = (state != IDLE) | !empty;
    assign status  = {28'd0, overflow, empty, full, busy};

    // A new access is taken only when no ack is pending, so cyc held past ack
    // yields one access every second cycle.
    assign accept  = wb.cyc & !wb.ack;
    assign wr_data = accept & wb.we & !wb.adr;
    assign push    = wr_data & !full;
    assign ovf_set = wr_data & full;
    assign ovf_clr = accept & !wb.we & wb.adr;

    // Bus response and sticky overflow flag
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wb.ack   <= 1'b0;
            wb.rdt   <= 32'd0;
            overflow <= 1'b0;
        end else begin
            wb.ack <= accept;
            wb.rdt <= (accept & !wb.we) ? status : 32'd0;
            if (ovf_set)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= wb.dat[7:0];
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (!empty) state_nx = START;
            START: if (baud == '0) state_nx = DATA;
            DATA:  if ((baud == '0) && (bit_idx == 3'd7)) state_nx = STOP;
            STOP:  if (baud == '0) state_nx = empty ? IDLE : START;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: next values of the serialiser datapath and FIFO pop
    always_comb begin
        pop     = 1'b0;
        baud_nx = baud;
        bit_nx  = bit_idx;
        sh_nx   = sh;
        tx_nx   = o_tx;
        case (state)
            IDLE: begin
                tx_nx = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_nx   = mem[rd_ptr];
                    baud_nx = BAUD_RELOAD;
                    tx_nx   = 1'b0;
                end
            end
            START: begin
                if (baud == '0) begin
                    tx_nx   = sh[0];
                    bit_nx  = 3'd0;
                    baud_nx = BAUD_RELOAD;
                end else begin
                    baud_nx = baud - BW'(1);
                end
            end
            DATA: begin
                if (baud == '0) begin
                    baud_nx = BAUD_RELOAD;
                    if (bit_idx == 3'd7) begin
                        tx_nx = 1'b1;
                    end else begin
                        sh_nx  = sh >> 1;
                        tx_nx  = sh[1];
                        bit_nx = bit_idx + 3'd1;
                    end
                end else begin
                    baud_nx = baud - BW'(1);
                end
            end
            STOP: begin
                if (baud == '0) begin
                    // Back-to-back frames: next start bit follows the stop bit directly
                    if (!empty) begin
                        pop     = 1'b1;
                        sh_nx   = mem[rd_ptr];
                        baud_nx = BAUD_RELOAD;
                        tx_nx   = 1'b0;
                    end
                end else begin
                    baud_nx = baud - BW'(1);
                end
            end
            default: tx_nx = 1'b1;
        endcase
    end

    // Serialiser datapath registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            baud    <= '0;
            bit_idx <= '0;
            sh      <= '0;
            o_tx    <= 1'b1;
        end else begin
            baud    <= baud_nx;
            bit_idx <= bit_nx;
            sh      <= sh_nx;
            o_tx    <= tx_nx;
        end
    end

endmodule
